// File: rtl/ase_hssi_log_pkg.sv
// Shared types and default widths for the HSSI event-logger arbiter.
package ase_hssi_log_pkg;

   localparam int DEF_CODE_W = 8;
   localparam int DEF_DATA_W = 64;
   localparam int DEF_CNT_W  = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GAP  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Width needed to index n items, never less than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ase_hssi_rr_arbiter.sv
// Round-robin picker: first valid request at or after the pointer wins; the
// pointer moves just past the winner only when the caller accepts the grant.
module ase_hssi_rr_arbiter
   import ase_hssi_log_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int SRC_W   = idx_w(NUM_SRC)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] req,
   input  logic               advance,
   output logic [NUM_SRC-1:0] grant,
   output logic [SRC_W-1:0]   grant_idx
);

   logic [SRC_W-1:0] ptr_q, ptr_d;
   logic             found;
   int               idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = (int'(ptr_q) + k) % NUM_SRC;
         if (!found && req[idx]) begin
            found     = 1'b1;
            grant_idx = SRC_W'(idx);
         end
      end
      if (found) begin
         grant[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance) begin
         ptr_d = (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + SRC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/ase_hssi_log_arbiter.sv
// Shares the HSSI event-logger message port among NUM_SRC requesters, with an
// optional quiet gap after each message and an end-of-sim flush sequence.
module ase_hssi_log_arbiter
   import ase_hssi_log_pkg::*;
#(
   parameter int NUM_SRC    = 4,
   parameter int CODE_W     = DEF_CODE_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int GAP_CYCLES = 0,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int SRC_W      = idx_w(NUM_SRC)
) (
   input  logic                      clk,
   input  logic                      SoftReset,
   input  logic [NUM_SRC-1:0]        req_valid,
   output logic [NUM_SRC-1:0]        req_ready,
   input  logic [NUM_SRC-1:0]        req_ts_en,
   input  logic [NUM_SRC*CODE_W-1:0] req_code,
   input  logic [NUM_SRC*DATA_W-1:0] req_data,
   input  logic                      finish_req,
   output logic                      finish_done,
   output logic                      log_string_en,
   output logic                      log_timestamp_en,
   output logic [SRC_W-1:0]          log_src,
   output logic [CODE_W-1:0]         log_code,
   output logic [DATA_W-1:0]         log_data,
   output logic [CNT_W-1:0]          msg_count
);

   localparam int               GAP_W    = idx_w(GAP_CYCLES + 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

   state_e              state_q, state_d;
   logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
   logic                finish_pend_q, finish_pend_d;
   logic                finish_done_q, finish_done_d;
   logic                str_q, str_d;
   logic                ts_q, ts_d;
   logic [SRC_W-1:0]    src_q, src_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [CNT_W-1:0]    count_q, count_d;

   logic [NUM_SRC-1:0]  arb_grant;
   logic [SRC_W-1:0]    arb_idx;
   logic                finish_active;
   logic                grant_en;

   // A finish request blocks grants in the very cycle it arrives.
   assign finish_active = finish_req | finish_pend_q;
   assign grant_en      = !SoftReset && (state_q == ST_IDLE) && (|req_valid) && !finish_active;
   assign req_ready     = grant_en ? arb_grant : '0;

   ase_hssi_rr_arbiter #(
      .NUM_SRC (NUM_SRC),
      .SRC_W   (SRC_W)
   ) u_rr (
      .clk       (clk),
      .rst       (SoftReset),
      .req       (req_valid),
      .advance   (grant_en),
      .grant     (arb_grant),
      .grant_idx (arb_idx)
   );

   always_comb begin
      state_d       = state_q;
      gap_cnt_d     = gap_cnt_q;
      finish_pend_d = finish_pend_q | finish_req;
      finish_done_d = finish_done_q;
      str_d         = 1'b0;
      ts_d          = ts_q;
      src_d         = src_q;
      code_d        = code_q;
      data_d        = data_q;
      count_d       = count_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_en) begin
               str_d  = 1'b1;
               ts_d   = req_ts_en[arb_idx];
               src_d  = arb_idx;
               code_d = req_code[arb_idx*CODE_W +: CODE_W];
               data_d = req_data[arb_idx*DATA_W +: DATA_W];
               if (count_q != '1) begin
                  count_d = count_q + CNT_W'(1);
               end
               if (GAP_CYCLES > 0) begin
                  state_d   = ST_GAP;
                  gap_cnt_d = GAP_LOAD;
               end
            end else if (finish_active && !str_q) begin
               // Flush completes only once the last strobe has left.
               state_d       = ST_DONE;
               finish_done_d = 1'b1;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q <= GAP_W'(1)) begin
               state_d   = ST_IDLE;
               gap_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (SoftReset) begin
         state_q       <= ST_IDLE;
         gap_cnt_q     <= '0;
         finish_pend_q <= 1'b0;
         finish_done_q <= 1'b0;
         str_q         <= 1'b0;
         ts_q          <= 1'b0;
         src_q         <= '0;
         code_q        <= '0;
         data_q        <= '0;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         gap_cnt_q     <= gap_cnt_d;
         finish_pend_q <= finish_pend_d;
         finish_done_q <= finish_done_d;
         str_q         <= str_d;
         ts_q          <= ts_d;
         src_q         <= src_d;
         code_q        <= code_d;
         data_q        <= data_d;
         count_q       <= count_d;
      end
   end

   assign finish_done      = finish_done_q;
   assign log_string_en    = str_q;
   assign log_timestamp_en = ts_q;
   assign log_src          = src_q;
   assign log_code         = code_q;
   assign log_data         = data_q;
   assign msg_count        = count_q;

endmodule

// File: tb/tb_ase_hssi_log_arbiter.sv
// Directed bench: four arbiter instances (gap 0, 2, 3, and a 2-bit counter)
// share one set of requester inputs; each scenario checks the relevant one.
module tb_ase_hssi_log_arbiter;

   localparam int N  = 4;
   localparam int CW = 8;
   localparam int DW = 64;

   logic              clk = 1'b0;
   logic              soft_reset;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ts_en;
   logic [N*CW-1:0]   req_code;
   logic [N*DW-1:0]   req_data;
   logic              finish_req;

   logic [N-1:0]  rdy_a, rdy_b, rdy_c, rdy_s;
   logic          done_a, done_b, done_c, done_s;
   logic          str_a, str_b, str_c, str_s;
   logic          ts_a, ts_b, ts_c, ts_s;
   logic [1:0]    src_a, src_b, src_c, src_s;
   logic [CW-1:0] code_a, code_b, code_c, code_s;
   logic [DW-1:0] data_a, data_b, data_c, data_s;
   logic [31:0]   cnt_a, cnt_b, cnt_c;
   logic [1:0]    cnt_s;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];
   int          e;

   // clock block
   always #5 clk = ~clk;

   ase_hssi_log_arbiter #(.NUM_SRC(N), .CODE_W(CW), .DATA_W(DW), .GAP_CYCLES(0), .CNT_W(32)) dut_a (
      .clk(clk), .SoftReset(soft_reset), .req_valid(req_valid), .req_ready(rdy_a),
      .req_ts_en(req_ts_en), .req_code(req_code), .req_data(req_data),
      .finish_req(finish_req), .finish_done(done_a), .log_string_en(str_a),
      .log_timestamp_en(ts_a), .log_src(src_a), .log_code(code_a), .log_data(data_a),
      .msg_count(cnt_a));

   ase_hssi_log_arbiter #(.NUM_SRC(N), .CODE_W(CW), .DATA_W(DW), .GAP_CYCLES(2), .CNT_W(32)) dut_b (
      .clk(clk), .SoftReset(soft_reset), .req_valid(req_valid), .req_ready(rdy_b),
      .req_ts_en(req_ts_en), .req_code(req_code), .req_data(req_data),
      .finish_req(finish_req), .finish_done(done_b), .log_string_en(str_b),
      .log_timestamp_en(ts_b), .log_src(src_b), .log_code(code_b), .log_data(data_b),
      .msg_count(cnt_b));

   ase_hssi_log_arbiter #(.NUM_SRC(N), .CODE_W(CW), .DATA_W(DW), .GAP_CYCLES(3), .CNT_W(32)) dut_c (
      .clk(clk), .SoftReset(soft_reset), .req_valid(req_valid), .req_ready(rdy_c),
      .req_ts_en(req_ts_en), .req_code(req_code), .req_data(req_data),
      .finish_req(finish_req), .finish_done(done_c), .log_string_en(str_c),
      .log_timestamp_en(ts_c), .log_src(src_c), .log_code(code_c), .log_data(data_c),
      .msg_count(cnt_c));

   ase_hssi_log_arbiter #(.NUM_SRC(N), .CODE_W(CW), .DATA_W(DW), .GAP_CYCLES(0), .CNT_W(2)) dut_s (
      .clk(clk), .SoftReset(soft_reset), .req_valid(req_valid), .req_ready(rdy_s),
      .req_ts_en(req_ts_en), .req_code(req_code), .req_data(req_data),
      .finish_req(finish_req), .finish_done(done_s), .log_string_en(str_s),
      .log_timestamp_en(ts_s), .log_src(src_s), .log_code(code_s), .log_data(data_s),
      .msg_count(cnt_s));

   // scoreboard check
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [N-1:0] oh(input int i);
      logic [N-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // driver tasks
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic do_reset();
      soft_reset = 1'b1;
      req_valid  = '0;
      finish_req = 1'b0;
      cyc();
      cyc();
      soft_reset = 1'b0;
   endtask

   initial begin
      soft_reset = 1'b1;
      req_valid  = '0;
      req_ts_en  = '0;
      req_code   = '0;
      req_data   = '0;
      finish_req = 1'b0;
      do_reset();

      // reset state
      smp();
      check("rst_rdy", rdy_a, 0);
      check("rst_str", str_a, 0);
      check("rst_done", done_a, 0);
      check("rst_cnt", cnt_a, 0);
      check("rst_src", src_a, 0);

      // 1: single request on port 2
      cyc();
      req_valid = 4'b0100;
      req_ts_en = 4'b0100;
      req_code[2*CW +: CW] = 8'h5A;
      req_data[2*DW +: DW] = 64'h1234;
      smp();
      check("t1_rdy", rdy_a, 4'b0100);
      cyc();
      req_valid = '0;
      smp();
      check("t1_str", str_a, 1);
      check("t1_src", src_a, 2);
      check("t1_code", code_a, 8'h5A);
      check("t1_data", data_a, 64'h1234);
      check("t1_ts", ts_a, 1);
      check("t1_cnt", cnt_a, 1);
      cyc();
      smp();
      check("t1_str_off", str_a, 0);

      // 2: all four valid, no gap
      do_reset();
      req_valid = '1;
      req_ts_en = 4'b0101;
      for (int i = 0; i < N; i++) begin
         req_code[i*CW +: CW] = 8'h10 + 8'(i);
         req_data[i*DW +: DW] = 64'(i) + 64'hA00;
      end
      for (int r = 0; r < 8; r++) exp_q.push_back(64'(r % 4));
      smp();
      check("t2_rdy0", rdy_a, 4'b0001);
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (i == 7) req_valid = '0;
         smp();
         e = int'(exp_q.pop_front());
         check("t2_str", str_a, 1);
         check("t2_src", src_a, 64'(e));
         check("t2_code", code_a, 64'(8'h10 + 8'(e)));
         check("t2_data", data_a, 64'(e) + 64'hA00);
         check("t2_ts", ts_a, (e % 2 == 0) ? 1 : 0);
         if (exp_q.size() > 0) check("t2_rdy", rdy_a, oh(int'(exp_q[0])));
      end
      check("t2_cnt", cnt_a, 8);
      check("t2_cnt_sat", cnt_s, 2'b11);
      cyc();
      smp();
      check("t2_str_off", str_a, 0);

      // 3: gap of 2, ports 0 and 3
      do_reset();
      req_valid = 4'b1001;
      exp_q.push_back(0); exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(3);
      for (int k = 0; k < 4; k++) begin
         e = int'(exp_q.pop_front());
         smp();
         check("t3_rdy", rdy_b, oh(e));
         cyc();
         smp();
         check("t3_str", str_b, 1);
         check("t3_src", src_b, 64'(e));
         check("t3_gap_rdy1", rdy_b, 0);
         cyc();
         smp();
         check("t3_gap_str", str_b, 0);
         check("t3_gap_rdy2", rdy_b, 0);
         cyc();
      end
      req_valid = '0;
      check("t3_cnt", cnt_b, 4);

      // 4: finish together with a request in IDLE
      do_reset();
      req_valid  = 4'b0010;
      finish_req = 1'b1;
      smp();
      check("t4_rdy_blocked", rdy_a, 0);
      cyc();
      finish_req = 1'b0;
      smp();
      check("t4_done", done_a, 1);
      check("t4_rdy_held", rdy_a, 0);
      check("t4_no_str", str_a, 0);
      check("t4_cnt", cnt_a, 0);
      cyc();
      smp();
      check("t4_done_sticky", done_a, 1);
      check("t4_rdy_still", rdy_a, 0);

      // 5: gap of 3, finish arrives inside the gap
      do_reset();
      req_valid = 4'b0001;
      smp();
      check("t5_rdy", rdy_c, 4'b0001);
      cyc();
      smp();
      check("t5_str", str_c, 1);
      cyc();
      finish_req = 1'b1;
      smp();
      check("t5_done_gap1", done_c, 0);
      cyc();
      finish_req = 1'b0;
      smp();
      check("t5_done_gap2", done_c, 0);
      check("t5_rdy_gap", rdy_c, 0);
      cyc();
      smp();
      check("t5_done_idle", done_c, 0);
      check("t5_rdy_pend", rdy_c, 0);
      cyc();
      smp();
      check("t5_done", done_c, 1);
      check("t5_no_str", str_c, 0);
      check("t5_cnt", cnt_c, 1);
      req_valid = '0;

      // 6: reset mid-gap with pointer at 2
      do_reset();
      req_valid = 4'b0010;
      req_code[1*CW +: CW] = 8'h61;
      smp();
      check("t6_rdy1", rdy_b, 4'b0010);
      cyc();
      req_valid = '0;
      smp();
      check("t6_str", str_b, 1);
      soft_reset = 1'b1;
      req_valid  = 4'b1010;
      cyc();
      smp();
      check("t6_rst_rdy", rdy_b, 0);
      check("t6_rst_str", str_b, 0);
      check("t6_rst_src", src_b, 0);
      check("t6_rst_code", code_b, 0);
      check("t6_rst_cnt", cnt_b, 0);
      check("t6_rst_done", done_b, 0);
      soft_reset = 1'b0;
      #1;
      check("t6_rdy_after", rdy_b, 4'b0010);
      cyc();
      smp();
      check("t6_str_after", str_b, 1);
      check("t6_src_after", src_b, 1);
      req_valid = '0;

      // final report
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
